fft8_host_ctrl: RTL

//  Host-side counterpart of the fft8 device interface. It accepts a serial stream of real

---
 rtl/fft8_host_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fft8_host_ctrl.sv
// fft8_host_ctrl
//   Host-side sequencer for an 8-point FFT core. Packs eight serial real
//   samples into fft_x0..fft_x7, strobes fft_isValid, waits (bounded) for
//   fft_resultValid, captures the 16 result words and replays them as eight
//   complex bins on a valid/ready stream. One frame in flight at a time.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   s_valid/s_ready/s_data   input sample stream (ready only while filling)
//   fft_isValid           one-cycle frame strobe to the core
//   fft_x0..fft_x7        frame samples, x0 = first accepted sample
//   fft_resultValid       core result strobe (honoured only while waiting)
//   fft_y0..fft_y7        real result bins
//   fft_y0_i..fft_y7_i    imaginary result bins
//   m_valid/m_ready       output bin handshake
//   m_re/m_im/m_idx       current bin value and index
//   m_last                high with bin 7
//   timeout_err           one-cycle pulse when the wait for a result expires
module fft8_host_ctrl #(
    parameter int INT_SIZE    = 8,
    parameter int FRAC_SIZE   = 8,
    parameter int TIMEOUT_CYC = 64,
    localparam int W          = INT_SIZE + FRAC_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         fft_isValid,
    output logic [W-1:0] fft_x0,
    output logic [W-1:0] fft_x1,
    output logic [W-1:0] fft_x2,
    output logic [W-1:0] fft_x3,
    output logic [W-1:0] fft_x4,
    output logic [W-1:0] fft_x5,
    output logic [W-1:0] fft_x6,
    output logic [W-1:0] fft_x7,
    input  logic         fft_resultValid,
    input  logic [W-1:0] fft_y0,
    input  logic [W-1:0] fft_y1,
    input  logic [W-1:0] fft_y2,
    input  logic [W-1:0] fft_y3,
    input  logic [W-1:0] fft_y4,
    input  logic [W-1:0] fft_y5,
    input  logic [W-1:0] fft_y6,
    input  logic [W-1:0] fft_y7,
    input  logic [W-1:0] fft_y0_i,
    input  logic [W-1:0] fft_y1_i,
    input  logic [W-1:0] fft_y2_i,
    input  logic [W-1:0] fft_y3_i,
    input  logic [W-1:0] fft_y4_i,
    input  logic [W-1:0] fft_y5_i,
    input  logic [W-1:0] fft_y6_i,
    input  logic [W-1:0] fft_y7_i,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_re,
    output logic [W-1:0] m_im,
    output logic [2:0]   m_idx,
    output logic         m_last,
    output logic         timeout_err
);

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam int          TW       = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYC - 1);

    logic [1:0]    state;
    logic [2:0]    fill_cnt;
    logic [2:0]    idx;
    logic [TW-1:0] wait_cnt;
    logic [W-1:0]  x_r    [8];
    logic [W-1:0]  cap_re [8];
    logic [W-1:0]  cap_im [8];
    logic [W-1:0]  y_re   [8];
    logic [W-1:0]  y_im   [8];

    assign y_re = '{fft_y0, fft_y1, fft_y2, fft_y3, fft_y4, fft_y5, fft_y6, fft_y7};
    assign y_im = '{fft_y0_i, fft_y1_i, fft_y2_i, fft_y3_i,
                    fft_y4_i, fft_y5_i, fft_y6_i, fft_y7_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            fill_cnt <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                x_r[i]    <= '0;
                cap_re[i] <= '0;
                cap_im[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (s_valid) begin
                        x_r[fill_cnt] <= s_data;
                        fill_cnt      <= fill_cnt + 3'd1;
                        if (fill_cnt == 3'd7) state <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the final count beats the timeout.
                    if (fft_resultValid) begin
                        cap_re <= y_re;
                        cap_im <= y_im;
                        idx    <= '0;
                        state  <= DRAIN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fill_cnt <= '0;
                        state    <= FILL;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign s_ready     = (state == FILL);
    assign fft_isValid = (state == ISSUE);
    assign m_valid     = (state == DRAIN);
    assign m_idx       = idx;
    assign m_last      = m_valid && (idx == 3'd7);
    // Bin outputs read as zero outside DRAIN so the idle/reset view is clean.
    assign m_re        = m_valid ? cap_re[idx] : '0;
    assign m_im        = m_valid ? cap_im[idx] : '0;
    assign timeout_err = (state == WAIT) && !fft_resultValid && (wait_cnt == WAIT_LAST);

    assign fft_x0 = x_r[0];
    assign fft_x1 = x_r[1];
    assign fft_x2 = x_r[2];
    assign fft_x3 = x_r[3];
    assign fft_x4 = x_r[4];
    assign fft_x5 = x_r[5];
    assign fft_x6 = x_r[6];
    assign fft_x7 = x_r[7];

endmodule
